// File: rtl/scan_pkg.sv
// Shared types and sizes for the scan sequencer and its slot finder.
package scan_pkg;

  // Width of the decoder select and number of decoder outputs
  localparam int unsigned SEL_W = 3;
  localparam int unsigned NSLOT = 8;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDwell = 2'd1,
    StBlank = 2'd2
  } scan_state_t;

endpackage

// File: rtl/next_slot_finder.sv
// Combinational priority search for the next enabled slot.
// from_zero = 1 finds the lowest set bit in mask[last:0].
// from_zero = 0 finds the lowest set bit strictly above cur, up to last.
module next_slot_finder
  import scan_pkg::*;
(
  input  logic [NSLOT-1:0] mask,
  input  logic [SEL_W-1:0] cur,
  input  logic [SEL_W-1:0] last,
  input  logic             from_zero,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Ascending scan; the first hit is kept, so the lowest qualifying index wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!found && mask[i] && (i <= int'(last)) && (from_zero || (i > int'(cur)))) begin
        found = 1'b1;
        idx   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Timed scan sequencer driving sel/en of a 3-to-8 decoder. Walks enabled slots
// 0..LAST, holding en for DWELL cycles then blanking for BLANK cycles per slot.
// One-shot passes end with a done pulse; continuous passes wrap with a wrap pulse.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 1,
  parameter int unsigned LAST  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [NSLOT-1:0] mask,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  // Counter reload values; the counter counts down to zero inside each state
  localparam logic [7:0] DwellLoad = 8'(DWELL - 1);
  localparam logic [7:0] BlankLoad = (BLANK == 0) ? 8'd0 : 8'(BLANK - 1);
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(LAST);
  // Bits above LAST are dropped when the mask is latched
  localparam logic [NSLOT-1:0] LastMask = NSLOT'((1 << (LAST + 1)) - 1);

  scan_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [NSLOT-1:0] mask_q, mask_d;
  logic             cont_q, cont_d;

  logic             first_found, next_found;
  logic [SEL_W-1:0] first_idx, next_idx;
  logic             slot_end;
  logic [NSLOT-1:0] mask_in;

  assign mask_in = mask & LastMask;

  // First slot of a new pass, searched on the live mask input (start and wrap)
  next_slot_finder u_first (
    .mask      (mask_in),
    .cur       (sel_q),
    .last      (LastIdx),
    .from_zero (1'b1),
    .found     (first_found),
    .idx       (first_idx)
  );

  // Next slot within the current pass, searched on the latched mask
  next_slot_finder u_next (
    .mask      (mask_q),
    .cur       (sel_q),
    .last      (LastIdx),
    .from_zero (1'b0),
    .found     (next_found),
    .idx       (next_idx)
  );

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    en_d     = en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    cont_d   = cont_q;
    slot_end = 1'b0;

    if (stop) begin
      // Abort quietly: no done/wrap, sel holds
      state_d = StIdle;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mask_d = mask_in;
            cont_d = continuous;
            if (first_found) begin
              state_d = StDwell;
              sel_d   = first_idx;
              en_d    = 1'b1;
              busy_d  = 1'b1;
              cnt_d   = DwellLoad;
            end else begin
              done_d = 1'b1;
            end
          end
        end

        StDwell: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else if (BLANK != 0) begin
            state_d = StBlank;
            en_d    = 1'b0;
            cnt_d   = BlankLoad;
          end else begin
            slot_end = 1'b1;
          end
        end

        StBlank: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            slot_end = 1'b1;
          end
        end

        default: begin
          state_d = StIdle;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
        end
      endcase

      // Advance to the next enabled slot, wrap, or finish the pass
      if (slot_end) begin
        if (next_found) begin
          state_d = StDwell;
          sel_d   = next_idx;
          en_d    = 1'b1;
          cnt_d   = DwellLoad;
        end else if (cont_q && first_found) begin
          mask_d  = mask_in;
          state_d = StDwell;
          sel_d   = first_idx;
          en_d    = 1'b1;
          wrap_d  = 1'b1;
          cnt_d   = DwellLoad;
        end else begin
          // One-shot end, or continuous re-latch found an empty mask
          if (cont_q) begin
            mask_d = mask_in;
          end
          state_d = StIdle;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = 8'd0;
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= 8'd0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: default timing (DWELL=4, BLANK=1) on dut_a,
// zero-blank continuous scanning on dut_b. Inputs change and outputs are sampled
// on the falling edge.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] mask = 8'h00;

  logic [2:0] sel_a, sel_b;
  logic       en_a, busy_a, done_a, wrap_a;
  logic       en_b, busy_b, done_b, wrap_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL(4), .BLANK(1), .LAST(7)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .mask       (mask),
    .sel        (sel_a),
    .en         (en_a),
    .busy       (busy_a),
    .done       (done_a),
    .wrap       (wrap_a)
  );

  scan_sequencer #(.DWELL(4), .BLANK(0), .LAST(7)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .mask       (mask),
    .sel        (sel_b),
    .en         (en_b),
    .busy       (busy_b),
    .done       (done_b),
    .wrap       (wrap_b)
  );

  // Packed status {busy, done, wrap, en, sel}
  logic [6:0] st_a, st_b;
  assign st_a = {busy_a, done_a, wrap_a, en_a, sel_a};
  assign st_b = {busy_b, done_b, wrap_b, en_b, sel_b};

  function automatic logic [6:0] st(input logic b, input logic d, input logic w,
                                    input logic e, input logic [2:0] s);
    return {b, d, w, e, s};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Start asserted across exactly one rising edge; returns after that edge
  task automatic pulse_start(input logic [7:0] m, input logic cont);
    mask       = m;
    continuous = cont;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [2:0] t2_slots [3];

  initial begin
    t2_slots[0] = 3'd2;
    t2_slots[1] = 3'd5;
    t2_slots[2] = 3'd7;

    tick();
    apply_reset();
    check_eq("reset_a", 32'(st_a), 32'(st(0, 0, 0, 0, 3'd0)));
    check_eq("reset_b", 32'(st_b), 32'(st(0, 0, 0, 0, 3'd0)));

    // Full mask, one-shot: 8 slots of 4 dwell + 1 blank, done after 40 cycles
    pulse_start(8'hFF, 1'b0);
    for (int c = 0; c < 40; c++) begin
      check_eq("full_scan", 32'(st_a), 32'(st(1, 0, 0, (c % 5) < 4, 3'(c / 5))));
      tick();
    end
    check_eq("full_done", 32'(st_a), 32'(st(0, 1, 0, 0, 3'd7)));
    tick();
    check_eq("full_idle", 32'(st_a), 32'(st(0, 0, 0, 0, 3'd7)));

    // Sparse mask 2,5,7; start held and mask changed mid-pass must be ignored
    mask       = 8'b1010_0100;
    continuous = 1'b0;
    start      = 1'b1;
    tick();
    for (int c = 0; c < 15; c++) begin
      check_eq("sparse_scan", 32'(st_a), 32'(st(1, 0, 0, (c % 5) < 4, t2_slots[c / 5])));
      if (c == 1) mask = 8'hFF;
      if (c == 12) start = 1'b0;
      tick();
    end
    check_eq("sparse_done", 32'(st_a), 32'(st(0, 1, 0, 0, 3'd7)));
    tick();
    check_eq("sparse_idle", 32'(st_a), 32'(st(0, 0, 0, 0, 3'd7)));

    // Continuous 0x81 with BLANK=0: 0,7,0,7... en never drops, wrap on each return
    apply_reset();
    pulse_start(8'h81, 1'b1);
    for (int c = 0; c < 25; c++) begin
      check_eq("cont_scan", 32'(st_b),
               32'(st(1, 0, (c > 0) && (c % 8 == 0), 1, ((c / 4) % 2 == 1) ? 3'd7 : 3'd0)));
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("cont_stop", 32'(st_b), 32'(st(0, 0, 0, 0, 3'd0)));

    // Empty mask: immediate done, never busy
    apply_reset();
    pulse_start(8'h00, 1'b0);
    check_eq("empty_done", 32'(st_a), 32'(st(0, 1, 0, 0, 3'd0)));
    tick();
    check_eq("empty_idle", 32'(st_a), 32'(st(0, 0, 0, 0, 3'd0)));

    // Stop in the middle of slot 3 dwell
    apply_reset();
    pulse_start(8'hFF, 1'b0);
    repeat (16) tick();
    check_eq("pre_stop", 32'(st_a), 32'(st(1, 0, 0, 1, 3'd3)));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("stop_idle", 32'(st_a), 32'(st(0, 0, 0, 0, 3'd3)));
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("stop_no_done", 32'(st_a), 32'(st(0, 0, 0, 0, 3'd3)));
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_eq("start_stop", 32'(st_a), 32'(st(0, 0, 0, 0, 3'd3)));
    tick();
    check_eq("start_stop_hold", 32'(st_a), 32'(st(0, 0, 0, 0, 3'd3)));

    // Reset during blank of slot 4, then restart from the lowest slot
    apply_reset();
    pulse_start(8'hFF, 1'b0);
    repeat (24) tick();
    check_eq("pre_reset", 32'(st_a), 32'(st(1, 0, 0, 0, 3'd4)));
    rst_n = 1'b0;
    tick();
    check_eq("mid_reset", 32'(st_a), 32'(st(0, 0, 0, 0, 3'd0)));
    rst_n = 1'b1;
    pulse_start(8'hFF, 1'b0);
    check_eq("restart", 32'(st_a), 32'(st(1, 0, 0, 1, 3'd0)));
    repeat (5) tick();
    check_eq("restart_slot1", 32'(st_a), 32'(st(1, 0, 0, 1, 3'd1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
